tcam_access_arbiter: RTL and testbench

TCAM_ACCESS_ARBITER -- requirements
Module: tcam_access_arbiter

---
 rtl/tcam_arb_pkg.sv | 24 ++
 rtl/tcam_rr_arb.sv | 43 ++++
 rtl/tcam_access_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_tcam_access_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_arb_pkg.sv
// Shared encodings for the TCAM access arbiter: controller MODE commands and FSM states.
package tcam_arb_pkg;

  localparam int unsigned ModeW = 3;

  typedef enum logic [ModeW-1:0] {
    MODE_I   = 3'b000,
    MODE_W   = 3'b001,
    MODE_R   = 3'b010,
    MODE_F   = 3'b011,
    MODE_C   = 3'b100,
    MODE_RST = 3'b101
  } tcam_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3,
    ST_CFG     = 3'd4,
    ST_CFG_GAP = 3'd5
  } arb_state_e;

endpackage

// File: rtl/tcam_rr_arb.sv
// Round-robin requester pick: combinational selection starting at a registered pointer,
// pointer moves past the winner whenever the pick is consumed.
module tcam_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_c_o,
  output logic [IDX_W-1:0]   idx_c_o,
  output logic               any_c_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [31:0]      cand;
  logic             found;

  // First request at or after the pointer, wrapping modulo NUM_REQ
  always_comb begin
    gnt_c_o = '0;
    idx_c_o = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr_q) + off) % NUM_REQ;
      if (!found && req_i[IDX_W'(cand)]) begin
        found                   = 1'b1;
        idx_c_o                 = IDX_W'(cand);
        gnt_c_o[IDX_W'(cand)]   = 1'b1;
      end
    end
    any_c_o = |req_i;
    ptr_d   = adv_i ? IDX_W'((32'(idx_c_o) + 32'd1) % NUM_REQ) : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tcam_access_arbiter.sv
// Arbitrates lookup requesters and a config port onto a single TCAM controller,
// one transaction at a time; config and lookups alternate when both are pending.
module tcam_access_arbiter
  import tcam_arb_pkg::*;
#(
  parameter int unsigned ID_Width    = 4,
  parameter int unsigned AddressSize = 4,
  parameter int unsigned Bits        = 8,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned LOOKUP_LAT  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          lk_valid,
  input  logic [NUM_REQ*ID_Width-1:0] lk_id,
  output logic [NUM_REQ-1:0]          lk_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [ID_Width-1:0]         rsp_dst,
  input  logic                        cfg_valid,
  input  logic                        cfg_op,
  input  logic [AddressSize-1:0]      cfg_addr,
  input  logic [Bits-1:0]             cfg_data,
  input  logic [Bits-1:0]             cfg_mskb,
  input  logic                        cfg_vbi,
  output logic                        cfg_ready,
  output logic [2:0]                  MODE,
  output logic [ID_Width-1:0]         PacketID_In,
  output logic                        Vbe_In,
  output logic                        Dcs_In,
  output logic                        Vbi_In,
  output logic [Bits-1:0]             Data_In,
  output logic [Bits-1:0]             Mskb_In,
  output logic [AddressSize-1:0]      A_In,
  input  logic [ID_Width-1:0]         DstID_Out,
  output logic                        busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

  arb_state_e           state_q, state_d;
  logic                 last_cfg_q, last_cfg_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      lk_idx_q, lk_idx_d;
  logic [ID_Width-1:0]  rsp_dst_q, rsp_dst_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic                 busy_q, busy_d;
  tcam_mode_e           mode_q, mode_d;
  logic [ID_Width-1:0]  pid_q, pid_d;
  logic                 vbe_q, vbe_d, dcs_q, dcs_d, vbi_q, vbi_d;
  logic [Bits-1:0]      data_q, data_d, mskb_q, mskb_d;
  logic [AddressSize-1:0] addr_q, addr_d;

  logic [NUM_REQ-1:0]   rr_gnt;
  logic [IdxW-1:0]      rr_idx;
  logic                 rr_any, rr_adv, cfg_win;
  logic [ID_Width-1:0]  sel_id;

  tcam_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (lk_valid),
    .adv_i   (rr_adv),
    .gnt_c_o (rr_gnt),
    .idx_c_o (rr_idx),
    .any_c_o (rr_any)
  );

  // Next state, grants, and next values of the registered controller-side outputs.
  // Controller outputs are loaded on the entry edge so they are valid for the whole state.
  always_comb begin
    state_d    = state_q;
    last_cfg_d = last_cfg_q;
    cnt_d      = cnt_q;
    lk_idx_d   = lk_idx_q;
    rsp_dst_d  = rsp_dst_q;
    mode_d     = MODE_I;
    pid_d      = '0;
    vbe_d      = 1'b0;
    dcs_d      = 1'b0;
    vbi_d      = 1'b0;
    data_d     = '0;
    mskb_d     = '0;
    addr_d     = '0;
    lk_ready   = '0;
    cfg_ready  = 1'b0;
    rr_adv     = 1'b0;
    cfg_win    = cfg_valid && !(last_cfg_q && rr_any);
    sel_id     = lk_id[32'(rr_idx)*ID_Width +: ID_Width];

    unique case (state_q)
      ST_IDLE: begin
        if (rst_n && cfg_win) begin
          cfg_ready  = 1'b1;
          last_cfg_d = 1'b1;
          state_d    = ST_CFG;
          if (cfg_op) begin
            mode_d = MODE_F;
          end else begin
            mode_d = MODE_W;
            vbe_d  = 1'b1;
            dcs_d  = 1'b1;
            vbi_d  = cfg_vbi;
            data_d = cfg_data;
            mskb_d = cfg_mskb;
            addr_d = cfg_addr;
          end
        end else if (rst_n && rr_any) begin
          lk_ready   = rr_gnt;
          rr_adv     = 1'b1;
          last_cfg_d = 1'b0;
          lk_idx_d   = rr_idx;
          pid_d      = sel_id;
          mode_d     = MODE_C;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CntW'(LOOKUP_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_dst_d = DstID_Out;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ST_RESP:    state_d = ST_IDLE;
      ST_CFG:     state_d = ST_CFG_GAP;
      ST_CFG_GAP: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    rsp_valid_d = (state_d == ST_RESP) ? (NUM_REQ'(1) << lk_idx_q) : '0;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_cfg_q  <= 1'b0;
      cnt_q       <= '0;
      lk_idx_q    <= '0;
      rsp_dst_q   <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      mode_q      <= MODE_I;
      pid_q       <= '0;
      vbe_q       <= 1'b0;
      dcs_q       <= 1'b0;
      vbi_q       <= 1'b0;
      data_q      <= '0;
      mskb_q      <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_cfg_q  <= last_cfg_d;
      cnt_q       <= cnt_d;
      lk_idx_q    <= lk_idx_d;
      rsp_dst_q   <= rsp_dst_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      pid_q       <= pid_d;
      vbe_q       <= vbe_d;
      dcs_q       <= dcs_d;
      vbi_q       <= vbi_d;
      data_q      <= data_d;
      mskb_q      <= mskb_d;
      addr_q      <= addr_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_dst     = rsp_dst_q;
  assign busy        = busy_q;
  assign MODE        = mode_q;
  assign PacketID_In = pid_q;
  assign Vbe_In      = vbe_q;
  assign Dcs_In      = dcs_q;
  assign Vbi_In      = vbi_q;
  assign Data_In     = data_q;
  assign Mskb_In     = mskb_q;
  assign A_In        = addr_q;

endmodule

// File: tb/tb_tcam_access_arbiter.sv
// Bench for tcam_access_arbiter: arbitration table, directed corner sequences and a
// randomized run checked every cycle against a transaction-timeline reference model.
module tb_tcam_access_arbiter;

  localparam int unsigned IDW = 4, AW = 4, BW = 8, NR = 4, LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     lk_valid, lk_ready, rsp_valid;
  logic [NR*IDW-1:0] lk_id;
  logic [IDW-1:0]    rsp_dst, PacketID_In, DstID_Out;
  logic              cfg_valid, cfg_op, cfg_vbi, cfg_ready;
  logic [AW-1:0]     cfg_addr, A_In;
  logic [BW-1:0]     cfg_data, cfg_mskb, Data_In, Mskb_In;
  logic [2:0]        MODE;
  logic              Vbe_In, Dcs_In, Vbi_In, busy;

  tcam_access_arbiter #(
    .ID_Width(IDW), .AddressSize(AW), .Bits(BW), .NUM_REQ(NR), .LOOKUP_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_id(lk_id), .lk_ready(lk_ready),
    .rsp_valid(rsp_valid), .rsp_dst(rsp_dst),
    .cfg_valid(cfg_valid), .cfg_op(cfg_op), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_mskb(cfg_mskb), .cfg_vbi(cfg_vbi), .cfg_ready(cfg_ready),
    .MODE(MODE), .PacketID_In(PacketID_In), .Vbe_In(Vbe_In), .Dcs_In(Dcs_In),
    .Vbi_In(Vbi_In), .Data_In(Data_In), .Mskb_In(Mskb_In), .A_In(A_In),
    .DstID_Out(DstID_Out), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: the transaction in flight, described by its start cycle
  int            m_rr, m_t0, m_free_at, m_idx;
  logic          m_last_cfg, m_is_lk, m_op, m_vbi;
  logic [IDW-1:0] m_id, m_dst, prev_dst;
  logic [BW-1:0] m_data, m_mskb;
  logic [AW-1:0] m_addr;

  // Output snapshot of the current cycle, for directed checks
  logic [NR-1:0] s_lk_ready, s_rsp_valid;
  logic [IDW-1:0] s_rsp_dst, s_pid;
  logic          s_cfg_ready, s_busy, s_vbe, s_dcs, s_vbi;
  logic [2:0]    s_mode;
  logic [BW-1:0] s_data, s_mskb;
  logic [AW-1:0] s_addr;

  typedef struct {
    logic [NR-1:0] lk_v;
    logic          cfg_v;
    logic [NR-1:0] exp_lk;
    logic          exp_cfg;
  } vec_t;
  vec_t vec[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    logic [NR-1:0] e_lk, e_rsp;
    logic          e_cfg, e_busy;
    logic [2:0]    e_mode;
    logic [26:0]   e_bus;
    int d, w;
    e_lk = '0; e_rsp = '0; e_cfg = 1'b0; e_busy = 1'b0; e_mode = 3'b000; e_bus = '0;
    if (!rst_n) begin
      m_rr = 0; m_last_cfg = 1'b0; m_free_at = cyc; m_dst = '0;
    end else if (cyc < m_free_at) begin
      e_busy = 1'b1;
      d = cyc - m_t0;
      if (m_is_lk) begin
        if (d == 1) begin e_mode = 3'b100; e_bus = {m_id, 23'b0}; end
        if (d == int'(LAT) + 2) begin m_dst = prev_dst; e_rsp = NR'(1) << m_idx; end
      end else if (d == 1) begin
        if (m_op) e_mode = 3'b011;
        else begin
          e_mode = 3'b001;
          e_bus  = {4'b0, 1'b1, 1'b1, m_vbi, m_data, m_mskb, m_addr};
        end
      end
    end else begin
      w = -1;
      for (int i = 0; i < int'(NR); i++)
        if (w < 0 && lk_valid[(m_rr + i) % NR]) w = (m_rr + i) % NR;
      if (cfg_valid && !(m_last_cfg && w >= 0)) begin
        e_cfg = 1'b1; m_last_cfg = 1'b1; m_is_lk = 1'b0; m_t0 = cyc; m_free_at = cyc + 3;
        m_op = cfg_op; m_vbi = cfg_vbi; m_data = cfg_data; m_mskb = cfg_mskb; m_addr = cfg_addr;
      end else if (w >= 0) begin
        e_lk = NR'(1) << w; m_rr = (w + 1) % NR; m_last_cfg = 1'b0;
        m_is_lk = 1'b1; m_idx = w; m_id = lk_id[w*IDW +: IDW];
        m_t0 = cyc; m_free_at = cyc + int'(LAT) + 3;
      end
    end
    chk("lk_ready",  32'(lk_ready),  32'(e_lk));
    chk("cfg_ready", 32'(cfg_ready), 32'(e_cfg));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    chk("rsp_dst",   32'(rsp_dst),   32'(m_dst));
    chk("mode",      32'(MODE),      32'(e_mode));
    chk("tcam_bus",  32'({PacketID_In, Vbe_In, Dcs_In, Vbi_In, Data_In, Mskb_In, A_In}), 32'(e_bus));
    chk("busy",      32'(busy),      32'(e_busy));
    prev_dst = DstID_Out;
  endtask

  // One clock: sample at the falling edge, then return just after the next rising edge
  task automatic step();
    @(negedge clk);
    s_lk_ready = lk_ready; s_cfg_ready = cfg_ready; s_rsp_valid = rsp_valid; s_rsp_dst = rsp_dst;
    s_mode = MODE; s_pid = PacketID_In; s_vbe = Vbe_In; s_dcs = Dcs_In; s_vbi = Vbi_In;
    s_data = Data_In; s_mskb = Mskb_In; s_addr = A_In; s_busy = busy;
    model_check();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    lk_valid = '0; cfg_valid = 1'b0; cfg_op = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_mskb = '0; cfg_vbi = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    chk("rst_outputs", 32'({s_lk_ready, s_cfg_ready, s_rsp_valid, s_rsp_dst, s_mode, s_busy}), 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int gi, any_rsp;
    logic [7:0] g_idx[5];
    int         g_cyc[5];
    logic [1:0] f_seq[4];

    rst_n = 1'b0; lk_id = '0; DstID_Out = '0; prev_dst = '0;
    idle_inputs();
    m_rr = 0; m_last_cfg = 1'b0; m_free_at = 0; m_t0 = 0; m_dst = '0; m_is_lk = 1'b0;
    m_idx = 0; m_op = 1'b0; m_vbi = 1'b0; m_id = '0; m_data = '0; m_mskb = '0; m_addr = '0;
    @(posedge clk); #1;

    // Arbitration table, applied from reset so rr_ptr/last_cfg history is known
    vec[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    vec[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    vec[2]  = '{4'b1111, 1'b0, 4'b1000, 1'b0};
    vec[3]  = '{4'b1111, 1'b0, 4'b0001, 1'b0};
    vec[4]  = '{4'b0001, 1'b1, 4'b0000, 1'b1};
    vec[5]  = '{4'b0001, 1'b1, 4'b0001, 1'b0};
    vec[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    vec[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    vec[8]  = '{4'b0110, 1'b0, 4'b0010, 1'b0};
    vec[9]  = '{4'b0011, 1'b0, 4'b0001, 1'b0};
    vec[10] = '{4'b1000, 1'b1, 4'b0000, 1'b1};
    vec[11] = '{4'b1000, 1'b1, 4'b1000, 1'b0};
    do_reset();
    for (int v = 0; v < 12; v++) begin
      lk_valid = vec[v].lk_v; cfg_valid = vec[v].cfg_v; lk_id = 16'h4321;
      step();
      chk("tbl_lk_ready",  32'(s_lk_ready),  32'(vec[v].exp_lk));
      chk("tbl_cfg_ready", 32'(s_cfg_ready), 32'(vec[v].exp_cfg));
      idle_inputs();
      for (int k = 0; k < 8; k++) step();
    end

    // Single lookup on requester 2
    do_reset();
    lk_valid = 4'b0100; lk_id = 16'h0A00; DstID_Out = 4'h5;
    step();
    chk("single_grant", 32'(s_lk_ready), 32'h4);
    idle_inputs();
    step();
    chk("single_issue_mode", 32'(s_mode), 32'h4);
    chk("single_issue_pid",  32'(s_pid),  32'hA);
    for (int k = 0; k < int'(LAT); k++) begin
      step();
      chk("single_wait_mode", 32'(s_mode), 32'h0);
    end
    step();
    chk("single_rsp_valid", 32'(s_rsp_valid), 32'h4);
    chk("single_rsp_dst",   32'(s_rsp_dst),   32'h5);
    step();
    chk("single_rsp_pulse", 32'(s_rsp_valid), 32'h0);

    // Round-robin with all requesters held
    do_reset();
    gi = 0;
    for (int k = 0; k < 5; k++) begin g_idx[k] = 8'hff; g_cyc[k] = -100; end
    lk_valid = 4'b1111; lk_id = 16'h3210;
    for (int k = 0; k < 26; k++) begin
      step();
      if (s_lk_ready != 0 && gi < 5) begin
        for (int b = 0; b < int'(NR); b++) if (s_lk_ready[b]) g_idx[gi] = 8'(b);
        g_cyc[gi] = cyc;
        gi++;
      end
    end
    idle_inputs();
    for (int k = 0; k < 5; k++) chk("rr_order", 32'(g_idx[k]), 32'(k % 4));
    for (int k = 1; k < 5; k++) chk("rr_gap", 32'(g_cyc[k] - g_cyc[k-1]), 32'd6);
    for (int k = 0; k < 8; k++) step();

    // Fairness between config and lookup 1
    do_reset();
    gi = 0;
    for (int k = 0; k < 4; k++) f_seq[k] = 2'd0;
    cfg_valid = 1'b1; cfg_op = 1'b1; lk_valid = 4'b0010; lk_id = 16'h00B0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (gi < 4 && s_cfg_ready) begin f_seq[gi] = 2'd1; gi++; end
      else if (gi < 4 && s_lk_ready == 4'b0010) begin f_seq[gi] = 2'd2; gi++; end
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) chk("fair_seq", 32'(f_seq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
    for (int k = 0; k < 8; k++) step();

    // Config write
    do_reset();
    cfg_valid = 1'b1; cfg_op = 1'b0; cfg_addr = 4'd3; cfg_data = 8'hA0; cfg_mskb = 8'hF0; cfg_vbi = 1'b1;
    step();
    chk("wr_grant", 32'(s_cfg_ready), 32'd1);
    idle_inputs();
    step();
    chk("wr_mode", 32'(s_mode), 32'h1);
    chk("wr_bus", 32'({s_data, s_mskb, s_addr, s_vbi, s_vbe, s_dcs}), 32'({8'hA0, 8'hF0, 4'd3, 3'b111}));
    step();
    chk("wr_gap_mode", 32'(s_mode), 32'h0);
    chk("wr_gap_bus", 32'({s_data, s_mskb, s_addr, s_vbi, s_vbe, s_dcs}), 32'd0);

    // Flush
    do_reset();
    cfg_valid = 1'b1; cfg_op = 1'b1; cfg_addr = 4'd9; cfg_data = 8'h55; cfg_mskb = 8'h33; cfg_vbi = 1'b1;
    step();
    idle_inputs();
    step();
    chk("fl_mode", 32'(s_mode), 32'h3);
    chk("fl_bus", 32'({s_data, s_mskb, s_addr, s_vbi, s_vbe, s_dcs}), 32'd0);
    chk("fl_busy1", 32'(s_busy), 32'd1);
    step();
    chk("fl_busy2", 32'(s_busy), 32'd1);
    step();
    chk("fl_busy3", 32'(s_busy), 32'd0);

    // Reset while waiting on the controller
    do_reset();
    lk_valid = 4'b0001; lk_id = 16'h0007; DstID_Out = 4'h6;
    step();
    idle_inputs();
    step();
    step();
    rst_n = 1'b0;
    any_rsp = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (s_rsp_valid != 0) any_rsp++;
    end
    chk("rstw_outputs", 32'({s_rsp_dst, s_mode, s_busy, s_pid}), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_rsp_valid != 0) any_rsp++;
    end
    chk("rstw_no_rsp", 32'(any_rsp), 32'd0);
    lk_valid = 4'b0010; lk_id = 16'h00C0; DstID_Out = 4'h9;
    step();
    chk("rstw_regrant", 32'(s_lk_ready), 32'h2);
    idle_inputs();
    for (int k = 0; k < int'(LAT) + 2; k++) step();
    chk("rstw_rsp_valid", 32'(s_rsp_valid), 32'h2);
    chk("rstw_rsp_dst",   32'(s_rsp_dst),   32'h9);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      lk_valid  = NR'($urandom);
      lk_id     = 16'($urandom);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_op    = 1'($urandom);
      cfg_addr  = AW'($urandom);
      cfg_data  = BW'($urandom);
      cfg_mskb  = BW'($urandom);
      cfg_vbi   = 1'($urandom);
      DstID_Out = IDW'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
